// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - four-channel round-robin arbiter driving the 4:1 mux select
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       rel,    // current owner finished
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] sel_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic       leave;

    // Round-robin search: first requester at or after the priority pointer, wrapping 3 -> 0.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Any exit reason ends the grant once; sel holds the current owner index.
    assign leave = rel || !req[sel] || (cnt == HOLD_LIM);

    // State register; sel is the registered owner index and stays put while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'b00;
            ptr   <= 2'b00;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: grant on any request in IDLE, drop the grant on release, request loss or hold limit.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick;
                    cnt_nxt   = 8'd1;
                end
            end
            GRANT: begin
                if (leave) begin
                    state_nxt = IDLE;
                    ptr_nxt   = sel + 2'd1;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode from registers only, so req/rel never reach them combinationally.
    always_comb begin
        busy = (state == GRANT);
        gnt  = busy ? (4'b0001 << sel) : 4'b0000;
    end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Four-channel round-robin arbiter that generates the 2-bit select for the downstream 4:1 data-flow multiplexer (`mux4to1`). It accepts per-channel requests, registers a one-hot grant plus the matching binary select, and holds the grant until release, request drop or a hold-time limit. A rotating priority pointer gives every requester fair access to the shared mux output.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles a single grant may stay asserted (legal range 1..255).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 4: channel requests; bit i requests mux input i (0=a, 1=b, 2=c, 3=d).
- `release` in 1: current owner finished; honoured only while a grant is active.
- `sel` out 2: mux select, binary index of the granted channel; drives `mux4to1.sel`.
- `gnt` out 4: one-hot grant, all-zero when no grant is active.
- `busy` out 1: high while a grant is active; equals `|gnt`.

## Operation
- Reset values: `sel`=2'b00, `gnt`=4'b0000, `busy`=0, priority pointer `ptr`=0, hold counter=0, state=IDLE.
- Two states: IDLE, GRANT.
- IDLE:
  - if `req`==0, stay in IDLE; outputs unchanged (`sel` keeps its last value so the mux output stays stable).
  - else pick the first set bit searching `ptr`, `ptr+1`, ... modulo 4 (wrap 3→0); register `gnt`=one-hot(k), `sel`=k, `busy`=1, hold counter=1; go to GRANT.
- GRANT, owner k:
  - exit if any of: `release`=1; `req[k]`=0; hold counter == `MAX_HOLD`.
  - on exit: `gnt`=0, `busy`=0, `ptr`=(k+1) mod 4, hold counter=0, state=IDLE; `sel` holds k.
  - otherwise hold counter increments; `gnt`/`sel` unchanged. Changes on other `req` bits are ignored.
- Simultaneous exit conditions have an identical single effect; the pointer advances exactly once.
- `release` in IDLE is ignored and has no latched effect.
- `ptr` changes only on a grant exit, never in IDLE.
- Hold counter width: 8 bits, no wrap possible (cleared at `MAX_HOLD` ≤ 255).
- `MAX_HOLD`=1: every grant lasts exactly one cycle.

## Timing
- Grant latency: `req` sampled high in IDLE at edge N → `gnt`/`sel`/`busy` valid after edge N.
- Exit latency: exit condition sampled at edge M → `gnt`=0 after edge M.
- At least one dead cycle (`gnt`=0) between consecutive grants; minimum grant period 2 cycles.
- Maximum grant length: `MAX_HOLD` cycles of `gnt` high.
- Worst-case wait for a continuously requesting channel: 3 × (`MAX_HOLD` + 1) cycles.
- Reset mid-grant: `gnt`, `busy` and `sel` go to their reset values immediately (asynchronously), `ptr`=0; the first arbitration after `rst` deasserts follows the normal IDLE rule.
- All outputs registered; no combinational path from `req`/`release` to the outputs.

## Test plan
- Reset then `req`=4'b0101 held, `release` pulsed 1 cycle after each grant → grant order ch0, ch2, ch0, ch2; `sel` 00, 10, 00, 10; one dead cycle between grants.
- `req`=4'b1111 held, `release`=0, `MAX_HOLD`=8 → each `gnt` high exactly 8 cycles, order 0,1,2,3,0; `sel` cycles 00→01→10→11→00.
- Wrap-around: drive `ptr` to 3 (grant and release ch2), then `req`=4'b1001 → ch3 granted first, then ch0 (`sel`=11 then 00).
- Grant ch1, drop `req[1]` at cycle 3 while `req[2]`=1 → `gnt`=0 on the next cycle, then `gnt`=4'b0100, `sel`=10; `release` and timeout coinciding on a later grant advance `ptr` by one only.
- Assert `rst` mid-grant of ch3 → `gnt`=0000, `sel`=00, `busy`=0 immediately; after `rst` deasserts with `req`=4'b1010, ch1 is granted first.
- `MAX_HOLD`=1, `req`=4'b0010 held → `gnt` pattern 0010, 0000, 0010, … (one cycle on, one cycle off); `sel` stays 01 throughout.
